// File: rtl/dram_fifo16_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : dram_fifo16_pkg                                       |
// | Brief    : Shared sizes and helpers for the 16-entry DRAM FIFO   |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
package dram_fifo16_pkg;

    localparam int FIFO16_DEPTH = 16;  // entries in one RAM16X1D column
    localparam int FIFO16_AW    = 4;   // pointer width, wraps 15->0 on its own
    localparam int FIFO16_CW    = 5;   // occupancy width, holds 0..16

    // Occupancy after one cycle of accepted push/pop activity.
    function automatic logic [FIFO16_CW-1:0] fifo16_next_count(
        input logic [FIFO16_CW-1:0] cnt,
        input logic                 push,
        input logic                 pop
    );
        logic [FIFO16_CW-1:0] v;
        v = cnt;
        if (push && !pop) v = cnt + FIFO16_CW'(1);
        if (pop && !push) v = cnt - FIFO16_CW'(1);
        return v;
    endfunction

endpackage : dram_fifo16_pkg
`default_nettype wire

// File: rtl/dram_fifo16_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : dram_fifo16_mem                                       |
// | Brief    : WIDTH columns of 16x1 dual-port distributed RAM.      |
// |            Write port is synchronous, read port (DPO) is async.  |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module dram_fifo16_mem
    import dram_fifo16_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic [FIFO16_AW-1:0] waddr,
    input  logic                 we,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [FIFO16_AW-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    // One RAM16X1D-shaped column per data bit; only the DPRA/DPO read side
    // is used, so no SPO output exists here.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic r_ram [FIFO16_DEPTH];

        // Synchronous write through the A/WE port.
        always_ff @(posedge clk) begin
            if (we) r_ram[waddr] <= wdata[gi];
        end

        assign rdata[gi] = r_ram[raddr];
    end

endmodule : dram_fifo16_mem
`default_nettype wire

// File: rtl/dram_fifo16_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : dram_fifo16_ctrl                                      |
// | Brief    : 16-entry first-word-fall-through FIFO controller.     |
// |            Pointers, occupancy, registered flags and error       |
// |            pulses around a distributed-RAM storage array.        |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module dram_fifo16_ctrl
    import dram_fifo16_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 wr_en,
    output logic                 full,
    output logic [WIDTH-1:0]     rd_data,
    input  logic                 rd_en,
    output logic                 empty,
    output logic [FIFO16_CW-1:0] count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [FIFO16_CW-1:0] c_full_cnt = FIFO16_CW'(FIFO16_DEPTH);

    logic [FIFO16_AW-1:0] r_wr_ptr;
    logic [FIFO16_AW-1:0] r_rd_ptr;
    logic [FIFO16_CW-1:0] r_count;
    logic                 r_full;
    logic                 r_empty;
    logic                 r_overflow;
    logic                 r_underflow;

    logic                 w_pop_ok;
    logic                 w_push_ok;
    logic                 w_ram_we;
    logic [FIFO16_CW-1:0] w_count_nxt;

    // Accept decisions use only registered flags, so no request-to-flag path.
    // A push into a full FIFO is allowed when a pop frees the head slot in the
    // same cycle; an empty FIFO never bypasses, so its pop is refused.
    always_comb begin
        w_pop_ok    = rd_en & ~r_empty;
        w_push_ok   = wr_en & (~r_full | w_pop_ok);
        w_ram_we    = w_push_ok & ~reset & ~flush;
        w_count_nxt = fifo16_next_count(r_count, w_push_ok, w_pop_ok);
    end

    // Pointer, occupancy, flag and pulse registers; reset and flush both empty
    // the queue and swallow any requests presented in that cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + FIFO16_AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + FIFO16_AW'(1);
            r_count     <= w_count_nxt;
            r_full      <= (w_count_nxt == c_full_cnt);
            r_empty     <= (w_count_nxt == '0);
            r_overflow  <= wr_en & ~w_push_ok;
            r_underflow <= rd_en & ~w_pop_ok;
        end
    end

    // When full with push+pop, wr_ptr == rd_ptr: the async read still shows
    // the old head before the edge and the new word lands at the edge.
    dram_fifo16_mem #(
        .WIDTH (WIDTH)
    ) u_mem (
        .clk   (clk),
        .waddr (r_wr_ptr),
        .we    (w_ram_we),
        .wdata (wr_data),
        .raddr (r_rd_ptr),
        .rdata (rd_data)
    );

    assign full      = r_full;
    assign empty     = r_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule : dram_fifo16_ctrl
`default_nettype wire
